instruction_fetch: RTL and testbench

//  Consumer of the program counter: reads the 2-byte instruction at pc_addr

---
 rtl/instruction_fetch.sv | 185 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads a 2-byte instruction from 8-bit program
// memory at the current program counter address and assembles it into
// opcode / ir_addr. One pc_inc pulse is issued per byte consumed.
// Byte order: byte0 = {opcode[2:0], addr[12:8]}, byte1 = addr[7:0].
module instruction_fetch #(
    parameter int MEM_LAT = 1,
    parameter int LAT_CW  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [7:0]  mem_data,
    output logic        mem_rd,
    output logic        pc_inc,
    output logic        busy,
    output logic        ir_valid,
    output logic [2:0]  opcode,
    output logic [12:0] ir_addr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_HI  = 3'd1,
        INC_HI = 3'd2,
        RD_LO  = 3'd3,
        INC_LO = 3'd4
    } state_t;

    // Final count value of a read wait; the byte is sampled in that cycle.
    localparam logic [LAT_CW-1:0] LAST_CNT = LAT_CW'(MEM_LAT - 1);

    state_t             state_q, state_d;
    logic [LAT_CW-1:0]  cnt_q, cnt_d;
    logic [7:0]         byte0_q, byte0_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [12:0]        ir_addr_q, ir_addr_d;
    logic               mem_rd_q, mem_rd_d;
    logic               pc_inc_q, pc_inc_d;
    logic               busy_q, busy_d;
    logic               ir_valid_q, ir_valid_d;
    logic               lat_done_s;

    assign lat_done_s = (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush aborts any active fetch and beats a new start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fetch_start && !flush) begin
                    state_d = RD_HI;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_HI: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (lat_done_s) begin
                    state_d = INC_HI;
                end else begin
                    state_d = RD_HI;
                end
            end
            INC_HI: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (lat_done_s) begin
                    state_d = INC_LO;
                end else begin
                    state_d = RD_LO;
                end
            end
            INC_LO: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        mem_rd_d   = 1'b0;
        pc_inc_d   = 1'b0;
        busy_d     = 1'b1;
        ir_valid_d = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            RD_HI, RD_LO: begin
                mem_rd_d = 1'b1;
            end
            INC_HI: begin
                pc_inc_d = 1'b1;
            end
            INC_LO: begin
                pc_inc_d   = 1'b1;
                ir_valid_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Latency counter and byte capture; nothing is committed on a flush.
    always_comb begin
        cnt_d     = {LAT_CW{1'b0}};
        byte0_d   = byte0_q;
        opcode_d  = opcode_q;
        ir_addr_d = ir_addr_q;
        if ((state_q == RD_HI) || (state_q == RD_LO)) begin
            if (flush || lat_done_s) begin
                cnt_d = {LAT_CW{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(LAT_CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {LAT_CW{1'b0}};
        end
        if ((state_q == RD_HI) && lat_done_s && !flush) begin
            byte0_d = mem_data;
        end else begin
            byte0_d = byte0_q;
        end
        if ((state_q == RD_LO) && lat_done_s && !flush) begin
            opcode_d  = byte0_q[7:5];
            ir_addr_d = {byte0_q[4:0], mem_data};
        end else begin
            opcode_d  = opcode_q;
            ir_addr_d = ir_addr_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {LAT_CW{1'b0}};
            byte0_q    <= 8'd0;
            opcode_q   <= 3'd0;
            ir_addr_q  <= 13'd0;
            mem_rd_q   <= 1'b0;
            pc_inc_q   <= 1'b0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            byte0_q    <= byte0_d;
            opcode_q   <= opcode_d;
            ir_addr_q  <= ir_addr_d;
            mem_rd_q   <= mem_rd_d;
            pc_inc_q   <= pc_inc_d;
            busy_q     <= busy_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign pc_inc   = pc_inc_q;
    assign busy     = busy_q;
    assign ir_valid = ir_valid_q;
    assign opcode   = opcode_q;
    assign ir_addr  = ir_addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: three instances with latencies
// 1, 2 and 3, each fed by a small byte memory addressed by a model program
// counter that advances on every pc_inc pulse.
module tb_instruction_fetch;

    logic clk;
    logic rst_n;

    logic        fs_a, fl_a, rd_a, inc_a, busy_a, iv_a;
    logic        fs_b, fl_b, rd_b, inc_b, busy_b, iv_b;
    logic        fs_c, fl_c, rd_c, inc_c, busy_c, iv_c;
    logic [7:0]  md_a, md_b, md_c;
    logic [2:0]  op_a, op_b, op_c;
    logic [12:0] ia_a, ia_b, ia_c;

    logic [7:0] mem_a [0:15];
    logic [7:0] mem_b [0:15];
    logic [7:0] mem_c [0:15];
    logic [3:0] pc_a = 4'd0;
    logic [3:0] pc_b = 4'd0;
    logic [3:0] pc_c = 4'd0;

    int vectors    = 0;
    int miscompares = 0;
    int inc_cnt;

    instruction_fetch #(.MEM_LAT(1), .LAT_CW(4)) u_a (
        .clk(clk), .rst_n(rst_n), .fetch_start(fs_a), .flush(fl_a), .mem_data(md_a),
        .mem_rd(rd_a), .pc_inc(inc_a), .busy(busy_a), .ir_valid(iv_a),
        .opcode(op_a), .ir_addr(ia_a));

    instruction_fetch #(.MEM_LAT(2), .LAT_CW(4)) u_b (
        .clk(clk), .rst_n(rst_n), .fetch_start(fs_b), .flush(fl_b), .mem_data(md_b),
        .mem_rd(rd_b), .pc_inc(inc_b), .busy(busy_b), .ir_valid(iv_b),
        .opcode(op_b), .ir_addr(ia_b));

    instruction_fetch #(.MEM_LAT(3), .LAT_CW(4)) u_c (
        .clk(clk), .rst_n(rst_n), .fetch_start(fs_c), .flush(fl_c), .mem_data(md_c),
        .mem_rd(rd_c), .pc_inc(inc_c), .busy(busy_c), .ir_valid(iv_c),
        .opcode(op_c), .ir_addr(ia_c));

    assign md_a = mem_a[pc_a];
    assign md_b = mem_b[pc_b];
    assign md_c = mem_c[pc_c];

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model program counters.
    always @(posedge clk) begin
        if (inc_a) pc_a <= pc_a + 4'd1;
        if (inc_b) pc_b <= pc_b + 4'd1;
        if (inc_c) pc_c <= pc_c + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
            mem_c[i] = 8'h00;
        end
        mem_a[0] = 8'hA5; mem_a[1] = 8'h3C;
        mem_a[2] = 8'h12; mem_a[3] = 8'h34;
        mem_a[4] = 8'h9A; mem_a[5] = 8'hBC;
        mem_a[6] = 8'hE7; mem_a[7] = 8'hFF;
        mem_a[8] = 8'h3C; mem_a[9] = 8'h99;
        mem_b[0] = 8'h4B; mem_b[1] = 8'h21;
        mem_b[2] = 8'hFF; mem_b[3] = 8'h6D; mem_b[4] = 8'h5A;
        mem_c[0] = 8'hFF; mem_c[1] = 8'h01;

        fs_a = 1'b0; fl_a = 1'b0;
        fs_b = 1'b0; fl_b = 1'b0;
        fs_c = 1'b0; fl_c = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_mem_rd", 32'(rd_a), 32'(1'b0));
        chk("rst_pc_inc", 32'(inc_a), 32'(1'b0));
        chk("rst_busy", 32'(busy_a), 32'(1'b0));
        chk("rst_ir_valid", 32'(iv_a), 32'(1'b0));
        chk("rst_opcode", 32'(op_a), 32'(3'd0));
        chk("rst_ir_addr", 32'(ia_a), 32'(13'd0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // T1: L=1, bytes A5,3C.
        fs_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            fs_a = 1'b0;
            chk($sformatf("t1_mem_rd_c%0d", c), 32'(rd_a), 32'((c == 1) || (c == 3)));
            chk($sformatf("t1_pc_inc_c%0d", c), 32'(inc_a), 32'((c == 2) || (c == 4)));
            chk($sformatf("t1_ir_valid_c%0d", c), 32'(iv_a), 32'(c == 4));
            chk($sformatf("t1_busy_c%0d", c), 32'(busy_a), 32'((c >= 1) && (c <= 4)));
            if (c == 4) begin
                chk("t1_opcode", 32'(op_a), 32'(3'd5));
                chk("t1_ir_addr", 32'(ia_a), 32'(13'h053C));
            end
        end

        // Flush in IDLE beats fetch_start.
        fs_a = 1'b1; fl_a = 1'b1;
        step();
        fs_a = 1'b0; fl_a = 1'b0;
        chk("idle_flush_busy", 32'(busy_a), 32'(1'b0));
        chk("idle_flush_mem_rd", 32'(rd_a), 32'(1'b0));
        step();
        chk("idle_flush_busy2", 32'(busy_a), 32'(1'b0));

        // T3: L=1, fetch_start held for 12 cycles.
        fs_a = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            fs_a = (c < 12);
            chk($sformatf("t3_ir_valid_c%0d", c), 32'(iv_a), 32'((c == 4) || (c == 9) || (c == 14)));
            chk($sformatf("t3_pc_inc_c%0d", c), 32'(inc_a),
                32'((c == 2) || (c == 4) || (c == 7) || (c == 9) || (c == 12) || (c == 14)));
            if (c == 4) begin
                chk("t3_op1", 32'(op_a), 32'(3'd0));
                chk("t3_ia1", 32'(ia_a), 32'(13'h1234));
            end
            if (c == 9) begin
                chk("t3_op2", 32'(op_a), 32'(3'd4));
                chk("t3_ia2", 32'(ia_a), 32'(13'h1ABC));
            end
            if (c == 14) begin
                chk("t3_op3", 32'(op_a), 32'(3'd7));
                chk("t3_ia3", 32'(ia_a), 32'(13'h07FF));
            end
        end
        chk("t3_busy_end", 32'(busy_a), 32'(1'b0));

        // T2: L=3, bytes FF,01.
        fs_c = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            fs_c = 1'b0;
            chk($sformatf("t2_mem_rd_c%0d", c), 32'(rd_c), 32'(((c >= 1) && (c <= 3)) || ((c >= 5) && (c <= 7))));
            chk($sformatf("t2_pc_inc_c%0d", c), 32'(inc_c), 32'((c == 4) || (c == 8)));
            chk($sformatf("t2_busy_c%0d", c), 32'(busy_c), 32'((c >= 1) && (c <= 8)));
            chk($sformatf("t2_ir_valid_c%0d", c), 32'(iv_c), 32'(c == 8));
            if (c == 8) begin
                chk("t2_opcode", 32'(op_c), 32'(3'd7));
                chk("t2_ir_addr", 32'(ia_c), 32'(13'h1F01));
            end
        end

        // T4: L=2, a clean fetch (4B,21) then a fetch flushed in RD_LO.
        fs_b = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            fs_b = 1'b0;
            chk($sformatf("t4a_ir_valid_c%0d", c), 32'(iv_b), 32'(c == 6));
        end
        chk("t4a_opcode", 32'(op_b), 32'(3'd2));
        chk("t4a_ir_addr", 32'(ia_b), 32'(13'h0B21));
        fs_b = 1'b1;
        inc_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            step();
            fs_b = 1'b0;
            fl_b = (c == 4);
            if (inc_b) inc_cnt++;
            chk($sformatf("t4_pc_inc_c%0d", c), 32'(inc_b), 32'(c == 3));
            chk($sformatf("t4_ir_valid_c%0d", c), 32'(iv_b), 32'(1'b0));
            chk($sformatf("t4_busy_c%0d", c), 32'(busy_b), 32'(c <= 4));
            if (c == 4) chk("t4_mem_rd_c4", 32'(rd_b), 32'(1'b1));
            if (c == 5) chk("t4_mem_rd_c5", 32'(rd_b), 32'(1'b0));
        end
        fl_b = 1'b0;
        chk("t4_inc_total", 32'(inc_cnt), 32'(1));
        chk("t4_opcode_kept", 32'(op_b), 32'(3'd2));
        chk("t4_ir_addr_kept", 32'(ia_b), 32'(13'h0B21));

        // T6: L=2, fetch_start re-pulsed in c2 while busy; bytes 6D,5A.
        fs_b = 1'b1;
        inc_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            fs_b = (c == 2);
            if (inc_b) inc_cnt++;
            chk($sformatf("t6_ir_valid_c%0d", c), 32'(iv_b), 32'(c == 6));
            chk($sformatf("t6_busy_c%0d", c), 32'(busy_b), 32'(c <= 6));
        end
        chk("t6_inc_total", 32'(inc_cnt), 32'(2));
        chk("t6_opcode", 32'(op_b), 32'(3'd3));
        chk("t6_ir_addr", 32'(ia_b), 32'(13'h0D5A));

        // T5: L=1, async reset while in INC_HI, then a clean fetch (3C,99).
        fs_a = 1'b1;
        step();
        fs_a = 1'b0;
        step();
        chk("t5_pc_inc_before", 32'(inc_a), 32'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pc_inc", 32'(inc_a), 32'(1'b0));
        chk("t5_rst_busy", 32'(busy_a), 32'(1'b0));
        chk("t5_rst_mem_rd", 32'(rd_a), 32'(1'b0));
        chk("t5_rst_opcode", 32'(op_a), 32'(3'd0));
        chk("t5_rst_ir_addr", 32'(ia_a), 32'(13'd0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t5_idle_after_rst", 32'(busy_a), 32'(1'b0));
        fs_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            fs_a = 1'b0;
            chk($sformatf("t5_pc_inc_c%0d", c), 32'(inc_a), 32'((c == 2) || (c == 4)));
            chk($sformatf("t5_ir_valid_c%0d", c), 32'(iv_a), 32'(c == 4));
        end
        chk("t5_opcode", 32'(op_a), 32'(3'd1));
        chk("t5_ir_addr", 32'(ia_a), 32'(13'h1C99));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
